// File: rtl/adc_frame_rx.sv
// adc_frame_rx -- captures one frame of ADC samples into a local buffer,
// checks its length against the length selected by sample_mode, then
// drains the frame oldest-first over a valid/ready output.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous, active-high
//   sample_mode  frame length select (0=16, 1=32, 2=64, others keep last)
//   din_valid    din carries a sample this cycle
//   din          sample data from the ADC streamer
//   sync         end-of-frame pulse from the ADC streamer
//   out_ready    downstream accepts out_data
//   out_valid    out_data holds a buffered sample
//   out_data     buffered sample, oldest first
//   out_last     final sample of the frame
//   frame_done   one-cycle pulse when a frame is closed
//   frame_err    length mismatch or overflow on the closed frame
//   frame_len    samples stored in the current/last frame (0..64)
//   rx_overrun   sticky: sample arrived while not accepting
//   busy         high in any state other than IDLE
module adc_frame_rx #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        sample_mode,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  input  logic              sync,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              frame_done,
  output logic              frame_err,
  output logic [6:0]        frame_len,
  output logic              rx_overrun,
  output logic              busy
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0]  DEPTH_L = 7'(DEPTH);

  typedef enum logic [1:0] {IDLE, CAPTURE, CHECK, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [6:0]  frame_len_q, frame_len_d;
  logic [6:0]  expected_q, expected_d;
  logic [6:0]  rd_ptr_q, rd_ptr_d;
  logic        frame_err_q, frame_err_d;
  logic        overflow_q, overflow_d;
  logic        rx_overrun_q, rx_overrun_d;

  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    state_d      = state_q;
    frame_len_d  = frame_len_q;
    expected_d   = expected_q;
    rd_ptr_d     = rd_ptr_q;
    frame_err_d  = frame_err_q;
    overflow_d   = overflow_q;
    rx_overrun_d = rx_overrun_q;
    mem_we       = 1'b0;
    mem_waddr    = frame_len_q[AW-1:0];

    unique case (state_q)
      IDLE: begin
        if (din_valid) begin
          mem_we      = 1'b1;
          mem_waddr   = '0;
          frame_len_d = 7'd1;
          frame_err_d = 1'b0;
          case (sample_mode)
            4'd0:    expected_d = 7'd16;
            4'd1:    expected_d = 7'd32;
            4'd2:    expected_d = 7'd64;
            default: expected_d = expected_q;
          endcase
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        // A sample coincident with sync belongs to the frame being closed.
        if (din_valid) begin
          if (frame_len_q < DEPTH_L) begin
            mem_we      = 1'b1;
            frame_len_d = frame_len_q + 7'd1;
          end else begin
            overflow_d = 1'b1;
          end
        end
        if (sync) begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        frame_err_d = (frame_len_q != expected_q) | overflow_q;
        overflow_d  = 1'b0;
        rd_ptr_d    = '0;
        state_d     = DRAIN;
        if (din_valid) begin
          rx_overrun_d = 1'b1;
        end
      end

      DRAIN: begin
        if (din_valid) begin
          rx_overrun_d = 1'b1;
        end
        if (out_ready) begin
          if (rd_ptr_q == frame_len_q - 7'd1) begin
            state_d = IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + 7'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      frame_len_q  <= '0;
      expected_q   <= 7'd16;
      rd_ptr_q     <= '0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_len_q  <= frame_len_d;
      expected_q   <= expected_d;
      rd_ptr_q     <= rd_ptr_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  // Sample buffer carries no reset; contents are only read back for the
  // frame that was just captured.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= din;
    end
  end

  assign out_valid  = (state_q == DRAIN);
  assign out_data   = (state_q == DRAIN) ? mem[rd_ptr_q[AW-1:0]] : '0;
  assign out_last   = (state_q == DRAIN) && (rd_ptr_q == frame_len_q - 7'd1);
  assign frame_done = (state_q == CHECK);
  assign frame_err  = frame_err_q;
  assign frame_len  = frame_len_q;
  assign rx_overrun = rx_overrun_q;
  assign busy       = (state_q != IDLE);

endmodule
